cook_timer: RTL and testbench

- MM:SS BCD countdown timer, upstream of the magnetron controller; its timer_done output drives that controller's timer_done input.
- Digits are keyed in while the oven is idle.
- While magnetron_on (the controller's Q) is high, the count decrements once per second.
- Signals expiry to the controller (timer_done) and to the beeper (done_pulse).

---
 rtl/microwave_pkg.sv | 25 ++
 rtl/bcd_down_digit.sv | 49 ++++
 rtl/cook_timer.sv | 186 ++++++++++++++++++
 tb/tb_cook_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook timer: FSM state
// encoding and BCD digit limits used by the timer and its digit cells.
package microwave_pkg;

    // Timer control states; encoding is fixed so external tools can decode it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // count is 00:00, waiting for keypad entry
        ARMED  = 2'd1,   // count nonzero, not yet running
        RUN    = 2'd2,   // counting down while the magnetron is on
        PAUSED = 2'd3    // count nonzero, magnetron off mid-cook
    } state_e;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_WRAP = 4'd5;

    // True when a keypad code is a legal decimal digit.
    function automatic logic is_bcd(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown. Priority: clear, then keypad load,
// then decrement. On decrement from 0 it reloads wrap_val and raises
// borrow_out so the next more-significant digit decrements too.
module bcd_down_digit
    import microwave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load_en,
    input  bcd_t load_val,
    input  logic dec_en,
    input  bcd_t wrap_val,
    output bcd_t value,
    output bcd_t value_next,
    output logic borrow_out
);

    bcd_t value_q;
    bcd_t value_d;

    // Next digit value: clear beats load beats decrement.
    always_comb begin
        // NOTE: default first so every path assigns value_d; otherwise a latch is inferred.
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load_en) begin
            value_d = load_val;
        end else if (dec_en) begin
            value_d = (value_q == '0) ? wrap_val : value_q - 1'b1;
        end
    end

    // Digit register with asynchronous reset to zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign value_next = value_d;
    assign borrow_out = dec_en && (value_q == '0);

endmodule

// File: rtl/cook_timer.sv
// MM:SS BCD countdown timer feeding the magnetron controller. Digits are
// keyed in while stopped, the count drops once per second while the
// magnetron is on, and expiry is flagged by timer_done and done_pulse.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRESC_W       = 20
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clearn,
    input  logic             digit_valid,
    input  logic [BCD_W-1:0] digit,
    input  logic             magnetron_on,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             timer_done,
    output logic             done_pulse,
    output logic             running
);

    // Prescaler value on which a one-second tick fires.
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               timer_done_q, timer_done_d;
    logic               done_pulse_q, done_pulse_d;

    bcd_t min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;

    logic clear;
    logic entry_ok;
    logic count_zero;
    logic next_zero;
    logic tick;
    logic dec_sec_tens;
    logic dec_min_ones;
    logic dec_min_tens;
    logic unused_borrow;

    assign clear      = ~clearn;
    assign count_zero = ({min_tens, min_ones, sec_tens, sec_ones} == '0);
    assign next_zero  = ({min_tens_next, min_ones_next,
                          sec_tens_next, sec_ones_next} == '0);

    // Keypad entry only while stopped and not being cleared; bad codes dropped.
    assign entry_ok = clearn && digit_valid && !magnetron_on && is_bcd(digit)
                   && ((state_q == IDLE) || (state_q == ARMED));

    // One-second tick; gated on a nonzero count so 00:00 never wraps.
    assign tick = clearn && (state_q == RUN) && magnetron_on
               && (presc_q == TICK_LAST) && !count_zero;

    // Digit chain, least significant first. Entry shifts every digit left
    // by one position; the borrow ripples upward on each tick.
    bcd_down_digit u_sec_ones (
        .clk        (clk),
        .reset      (reset),
        .clr        (clear),
        .load_en    (entry_ok),
        .load_val   (digit),
        .dec_en     (tick),
        .wrap_val   (BCD_MAX),
        .value      (sec_ones),
        .value_next (sec_ones_next),
        .borrow_out (dec_sec_tens)
    );

    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .reset      (reset),
        .clr        (clear),
        .load_en    (entry_ok),
        .load_val   (sec_ones),
        .dec_en     (dec_sec_tens),
        .wrap_val   (SEC_TENS_WRAP),
        .value      (sec_tens),
        .value_next (sec_tens_next),
        .borrow_out (dec_min_ones)
    );

    bcd_down_digit u_min_ones (
        .clk        (clk),
        .reset      (reset),
        .clr        (clear),
        .load_en    (entry_ok),
        .load_val   (sec_tens),
        .dec_en     (dec_min_ones),
        .wrap_val   (BCD_MAX),
        .value      (min_ones),
        .value_next (min_ones_next),
        .borrow_out (dec_min_tens)
    );

    // The top borrow could only fire when decrementing from 00:00, which tick prevents.
    bcd_down_digit u_min_tens (
        .clk        (clk),
        .reset      (reset),
        .clr        (clear),
        .load_en    (entry_ok),
        .load_val   (min_ones),
        .dec_en     (dec_min_tens),
        .wrap_val   (BCD_MAX),
        .value      (min_tens),
        .value_next (min_tens_next),
        .borrow_out (unused_borrow)
    );

    // Next state, prescaler and expiry flags; clear dominates entry and tick.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        timer_done_d = next_zero;
        done_pulse_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (entry_ok) begin
            // Shifting can drop the only nonzero digit, so re-derive the state.
            state_d = next_zero ? IDLE : ARMED;
            presc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // magnetron_on with nothing to count is ignored.
                    state_d = IDLE;
                end
                ARMED: begin
                    if (magnetron_on) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!magnetron_on) begin
                        // Prescaler is held so the partial second survives the pause.
                        state_d = PAUSED;
                    end else if (count_zero) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (next_zero) begin
                            state_d      = IDLE;
                            done_pulse_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (magnetron_on) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control registers; reset leaves the timer idle and flagged as done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            timer_done_q <= 1'b1;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            timer_done_q <= timer_done_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign timer_done = timer_done_q;
    assign done_pulse = done_pulse_q;
    assign running    = (state_q == RUN);

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with a 4-cycle second.
module tb_cook_timer;

    logic       clk;
    logic       reset;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic       magnetron_on;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;
    logic       done_pulse;
    logic       running;

    int vectors     = 0;
    int miscompares = 0;

    cook_timer #(
        .TICKS_PER_SEC (4),
        .PRESC_W       (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clearn       (clearn),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .magnetron_on (magnetron_on),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .timer_done   (timer_done),
        .done_pulse   (done_pulse),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] count_now();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        clearn       = 1'b1;
        digit_valid  = 1'b0;
        digit        = 4'd0;
        magnetron_on = 1'b0;
        #2;
        check("reset_count",   count_now(), 16'h0000);
        check("reset_done",    timer_done,  1'b1);
        check("reset_pulse",   done_pulse,  1'b0);
        check("reset_running", running,     1'b0);
        steps(2);
        reset = 1'b0;
        step();

        // Keypad entry
        key(4'd0);
        check("key0_count", count_now(), 16'h0000);
        check("key0_done",  timer_done,  1'b1);
        key(4'd1); key(4'd3); key(4'd0);
        check("key130_count",   count_now(), 16'h0130);
        check("key130_done",    timer_done,  1'b0);
        check("key130_running", running,     1'b0);
        do_clear();
        check("clear_count", count_now(), 16'h0000);
        check("clear_done",  timer_done,  1'b1);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd7);
        check("shift_count", count_now(), 16'h2347);
        key(4'hA);
        check("badkey_count", count_now(), 16'h2347);
        check("badkey_done",  timer_done,  1'b0);

        // 00:03 full countdown
        do_clear();
        key(4'd3);
        magnetron_on = 1'b1;
        step();
        check("run3_running", running, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("run3_count_c%0d", c), count_now(), 16'(3 - c / 4));
            check($sformatf("run3_pulse_c%0d", c), done_pulse, (c == 12));
        end
        check("run3_done",    timer_done, 1'b1);
        check("run3_idle",    running,    1'b0);
        steps(3);
        check("idle_on_count", count_now(), 16'h0000);
        check("idle_on_pulse", done_pulse,  1'b0);
        check("idle_on_run",   running,     1'b0);
        magnetron_on = 1'b0;

        // Minute borrows: 01:00 -> 00:59, 10:00 -> 09:59
        do_clear();
        key(4'd1); key(4'd0); key(4'd0);
        magnetron_on = 1'b1;
        steps(5);
        check("borrow_0059", count_now(), 16'h0059);
        magnetron_on = 1'b0;
        step();
        do_clear();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        magnetron_on = 1'b1;
        steps(4);
        check("borrow_pre",  count_now(), 16'h1000);
        step();
        check("borrow_0959", count_now(), 16'h0959);
        magnetron_on = 1'b0;
        step();

        // 0:90 is a legal entry and counts down normally
        do_clear();
        key(4'd9); key(4'd0);
        check("load_0090", count_now(), 16'h0090);
        magnetron_on = 1'b1;
        steps(5);
        check("run_0089", count_now(), 16'h0089);
        magnetron_on = 1'b0;
        step();

        // Pause keeps the partial second; entry in PAUSED is ignored
        do_clear();
        key(4'd5);
        magnetron_on = 1'b1;
        steps(3);
        magnetron_on = 1'b0;
        step();
        check("pause_running", running, 1'b0);
        key(4'd7);
        steps(8);
        check("pause_count",  count_now(), 16'h0005);
        check("pause_still",  running,     1'b0);
        magnetron_on = 1'b1;
        step();
        check("resume_running", running,     1'b1);
        step();
        check("resume_c1",      count_now(), 16'h0005);
        step();
        check("resume_c2",      count_now(), 16'h0004);
        magnetron_on = 1'b0;
        step();

        // Clear during RUN beats a simultaneous tick and digit entry
        do_clear();
        key(4'd4); key(4'd0);
        check("load_0040", count_now(), 16'h0040);
        magnetron_on = 1'b1;
        steps(4);
        clearn      = 1'b0;
        digit_valid = 1'b1;
        digit       = 4'd5;
        step();
        clearn      = 1'b1;
        digit_valid = 1'b0;
        check("clrrun_count",   count_now(), 16'h0000);
        check("clrrun_done",    timer_done,  1'b1);
        check("clrrun_pulse",   done_pulse,  1'b0);
        check("clrrun_running", running,     1'b0);
        step();
        check("clrrun_pulse2",  done_pulse,  1'b0);
        magnetron_on = 1'b0;
        step();

        // Asynchronous reset mid-RUN
        do_clear();
        key(4'd2); key(4'd1); key(4'd5);
        check("load_0215", count_now(), 16'h0215);
        magnetron_on = 1'b1;
        steps(2);
        check("rst_pre_running", running, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("rstrun_count",   count_now(), 16'h0000);
        check("rstrun_done",    timer_done,  1'b1);
        check("rstrun_running", running,     1'b0);
        check("rstrun_pulse",   done_pulse,  1'b0);
        magnetron_on = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("rstrel_count", count_now(), 16'h0000);
        check("rstrel_pulse", done_pulse,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
